// File: rtl/iic_s_phy_byterx_if.sv
// Pin-level and user-side signals of the I2C target byte PHY.
// The slave modport is the PHY's view; the master modport is the view of
// whatever drives the pins and consumes the user side.
interface iic_s_phy_byterx_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic       usr_rvalid;
   logic [7:0] usr_rdata;
   logic       usr_wready;
   logic       usr_wvalid;
   logic [7:0] usr_wdata;
   logic       usr_evt_start;
   logic       usr_evt_rw;
   logic       usr_evt_stop;
   logic       dbg_err_underrun;

   modport slave (
      input  scl_in, sda_in, usr_wvalid, usr_wdata,
      output sda_oe, usr_rvalid, usr_rdata, usr_wready,
             usr_evt_start, usr_evt_rw, usr_evt_stop, dbg_err_underrun
   );

   modport master (
      output scl_in, sda_in, usr_wvalid, usr_wdata,
      input  sda_oe, usr_rvalid, usr_rdata, usr_wready,
             usr_evt_start, usr_evt_rw, usr_evt_stop, dbg_err_underrun
   );
endinterface

// File: rtl/iic_s_phy_byterx.sv
// I2C target byte PHY: oversamples SCL/SDA on clk_sys, decodes START/STOP,
// matches a 7-bit address, shifts write bytes out to the user and read
// bytes in from a one-entry holding register. SDA is open drain via sda_oe.
module iic_s_phy_byterx #(
   parameter logic [6:0] SLV_ADDR = 7'h50,
   parameter int         U_DLY    = 1
) (
   input  logic              clk_sys,
   input  logic              rst,
   iic_s_phy_byterx_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } state_t;

   // U_DLY only ever shaped simulation delays; this source carries none, so
   // the parameter is kept for instantiation compatibility and elaborates to nothing.
   if (U_DLY < 0) begin : g_u_dly_unused
   end

   // Pin synchronisers plus one compare stage each.
   logic r_scl_s1, r_scl_s2, r_scl_d;
   logic r_sda_s1, r_sda_s2, r_sda_d;

   // Protocol state.
   state_t     r_state, w_state_nxt;
   logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic       r_sda_oe, w_sda_oe_nxt;
   logic [7:0] r_rdata, w_rdata_nxt;
   logic       r_evt_rw, w_evt_rw_nxt;
   logic       r_matched, w_matched_nxt;
   logic       r_rd_first, w_rd_first_nxt;
   logic       r_rvalid, w_rvalid_nxt;
   logic       r_evt_start, w_evt_start_nxt;
   logic       r_evt_stop, w_evt_stop_nxt;
   logic       r_underrun, w_underrun_nxt;

   // Read holding register.
   logic       r_hold_vld;
   logic [7:0] r_hold_data;

   logic       w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0] w_byte;
   logic [7:0] w_load_byte;
   logic       w_rd_load;
   logic       w_hold_take;
   logic       w_hold_load;

   // Bring both pins into clk_sys and keep the previous synchronised level.
   always_ff @(posedge clk_sys) begin
      // NOTE: sequential state uses <= so every flop sees pre-edge values.
      if (rst) begin
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_scl_d  <= 1'b1;
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
         r_sda_d  <= 1'b1;
      end else begin
         r_scl_s1 <= bus.scl_in;
         r_scl_s2 <= r_scl_s1;
         r_scl_d  <= r_scl_s2;
         r_sda_s1 <= bus.sda_in;
         r_sda_s2 <= r_sda_s1;
         r_sda_d  <= r_sda_s2;
      end
   end

   assign w_scl_rise  = r_scl_s2 & ~r_scl_d;
   assign w_scl_fall  = ~r_scl_s2 & r_scl_d;
   assign w_start     = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
   assign w_stop      = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
   assign w_load_byte = r_hold_vld ? r_hold_data : 8'hFF;
   assign w_hold_load = bus.usr_wvalid & ~r_hold_vld;

   // Next-state and output decode; bus conditions override any SCL-edge work.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      w_state_nxt     = r_state;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_sda_oe_nxt    = r_sda_oe;
      w_rdata_nxt     = r_rdata;
      w_evt_rw_nxt    = r_evt_rw;
      w_matched_nxt   = r_matched;
      w_rd_first_nxt  = r_rd_first;
      w_rvalid_nxt    = 1'b0;
      w_evt_start_nxt = 1'b0;
      w_evt_stop_nxt  = 1'b0;
      w_underrun_nxt  = 1'b0;
      w_hold_take     = 1'b0;
      w_rd_load       = 1'b0;
      w_byte          = {r_shift[6:0], r_sda_s2};

      if (w_start) begin
         w_state_nxt    = ST_ADDR;
         w_bit_cnt_nxt  = 3'd0;
         w_sda_oe_nxt   = 1'b0;
         w_matched_nxt  = 1'b0;
         w_rd_first_nxt = 1'b0;
      end else if (w_stop) begin
         w_state_nxt    = ST_IDLE;
         w_bit_cnt_nxt  = 3'd0;
         w_sda_oe_nxt   = 1'b0;
         w_evt_stop_nxt = r_matched;
         w_matched_nxt  = 1'b0;
         w_rd_first_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = w_byte;
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     if (w_byte[7:1] == SLV_ADDR) begin
                        w_state_nxt     = ST_ADDR_ACK;
                        w_evt_start_nxt = 1'b1;
                        w_evt_rw_nxt    = w_byte[0];
                        w_matched_nxt   = 1'b1;
                     end else begin
                        w_state_nxt = ST_WAIT_STOP;
                     end
                  end
               end
            end
            // sda_oe doubles as the phase flag: the first fall starts the
            // ACK, the second ends it.
            ST_ADDR_ACK: begin
               if (w_scl_fall) begin
                  if (!r_sda_oe) begin
                     w_sda_oe_nxt = 1'b1;
                  end else if (r_evt_rw) begin
                     w_state_nxt = ST_RD_DATA;
                     w_rd_load   = 1'b1;
                  end else begin
                     w_state_nxt   = ST_WR_DATA;
                     w_sda_oe_nxt  = 1'b0;
                     w_bit_cnt_nxt = 3'd0;
                  end
               end
            end
            ST_WR_DATA: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = w_byte;
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     w_rdata_nxt  = w_byte;
                     w_rvalid_nxt = 1'b1;
                     w_state_nxt  = ST_WR_ACK;
                  end
               end
            end
            ST_WR_ACK: begin
               if (w_scl_fall) begin
                  if (!r_sda_oe) begin
                     w_sda_oe_nxt = 1'b1;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     w_state_nxt  = ST_WR_DATA;
                  end
               end
            end
            ST_RD_DATA: begin
               if (r_rd_first) begin
                  w_rd_load = w_scl_fall;
               end else if (w_scl_rise) begin
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     w_state_nxt = ST_RD_ACK;
                  end
               end else if (w_scl_fall) begin
                  // Rotate rather than shift so the register stays fully used.
                  w_shift_nxt  = {r_shift[6:0], r_shift[7]};
                  w_sda_oe_nxt = ~r_shift[6];
               end
            end
            ST_RD_ACK: begin
               if (w_scl_fall) begin
                  w_sda_oe_nxt = 1'b0;
               end else if (w_scl_rise) begin
                  if (!r_sda_s2) begin
                     w_state_nxt    = ST_RD_DATA;
                     w_rd_first_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_WAIT_STOP;
                  end
               end
            end
            default: begin
               // IDLE and WAIT_STOP ignore everything except START/STOP.
            end
         endcase

         // Start of a read byte: take the holding register, or send 0xFF.
         if (w_rd_load) begin
            w_shift_nxt    = w_load_byte;
            w_sda_oe_nxt   = ~w_load_byte[7];
            w_bit_cnt_nxt  = 3'd0;
            w_rd_first_nxt = 1'b0;
            w_hold_take    = r_hold_vld;
            w_underrun_nxt = ~r_hold_vld;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_sda_oe    <= 1'b0;
         r_rdata     <= 8'h00;
         r_evt_rw    <= 1'b0;
         r_matched   <= 1'b0;
         r_rd_first  <= 1'b0;
         r_rvalid    <= 1'b0;
         r_evt_start <= 1'b0;
         r_evt_stop  <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_sda_oe    <= w_sda_oe_nxt;
         r_rdata     <= w_rdata_nxt;
         r_evt_rw    <= w_evt_rw_nxt;
         r_matched   <= w_matched_nxt;
         r_rd_first  <= w_rd_first_nxt;
         r_rvalid    <= w_rvalid_nxt;
         r_evt_start <= w_evt_start_nxt;
         r_evt_stop  <= w_evt_stop_nxt;
         r_underrun  <= w_underrun_nxt;
      end
   end

   // Holding valid flag; a load in the same cycle as a take wins.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         r_hold_vld <= 1'b0;
      end else begin
         if (w_hold_take) r_hold_vld <= 1'b0;
         if (w_hold_load) r_hold_vld <= 1'b1;
      end
   end

   // Holding data captured on the user handshake.
   always_ff @(posedge clk_sys) begin
      // NOTE: no reset on the data; r_hold_vld alone qualifies its contents.
      if (w_hold_load) r_hold_data <= bus.usr_wdata;
   end

   assign bus.sda_oe           = r_sda_oe;
   assign bus.usr_rvalid       = r_rvalid;
   assign bus.usr_rdata        = r_rdata;
   assign bus.usr_wready       = ~r_hold_vld;
   assign bus.usr_evt_start    = r_evt_start;
   assign bus.usr_evt_rw       = r_evt_rw;
   assign bus.usr_evt_stop     = r_evt_stop;
   assign bus.dbg_err_underrun = r_underrun;

endmodule

// File: tb/tb_iic_s_phy_byterx.sv
// Bench for iic_s_phy_byterx: a bit-level I2C master drives the pins, a
// transaction-level model predicts ACKs, read bytes, received bytes and
// user events, and monitors count what the PHY actually produced.
module tb_iic_s_phy_byterx;
   localparam logic [6:0] SLV = 7'h50;
   localparam int         Q   = 8;   // clk_sys cycles per SCL quarter period

   logic       clk_sys = 1'b0;
   logic       rst     = 1'b1;
   logic       scl_m   = 1'b1;
   logic       sda_m   = 1'b1;
   logic       wvalid_m = 1'b0;
   logic [7:0] wdata_m  = 8'h00;

   iic_s_phy_byterx_if bus ();

   iic_s_phy_byterx #(.SLV_ADDR(SLV), .U_DLY(1)) dut (
      .clk_sys (clk_sys),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   // Open-drain wired-AND of master and target on SDA.
   assign bus.scl_in     = scl_m;
   assign bus.sda_in     = sda_m & ~bus.sda_oe;
   assign bus.usr_wvalid = wvalid_m;
   assign bus.usr_wdata  = wdata_m;

   int n_checks = 0;
   int n_errors = 0;

   // Observed activity.
   logic [7:0] rx_q[$];
   int n_start = 0, n_stop = 0, n_under = 0, n_oe = 0;

   // Expected activity.
   logic [7:0] exp_q[$];
   int   exp_start = 0, exp_stop = 0, exp_under = 0;
   logic exp_rw = 1'b0;

   always @(negedge clk_sys) begin
      if (bus.usr_rvalid)       rx_q.push_back(bus.usr_rdata);
      if (bus.usr_evt_start)    n_start++;
      if (bus.usr_evt_stop)     n_stop++;
      if (bus.dbg_err_underrun) n_under++;
      if (bus.sda_oe)           n_oe++;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk_sys);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic offer(input logic [7:0] d);
      int t;
      t = 0;
      while (bus.usr_wready !== 1'b1 && t < 50) begin
         @(negedge clk_sys);
         t++;
      end
      check("wready_before_offer", bus.usr_wready, 1);
      wdata_m  = d;
      wvalid_m = 1'b1;
      @(negedge clk_sys);
      wvalid_m = 1'b0;
   endtask

   // One SCL clock: master drives drv, samples the pin and sda_oe mid-high,
   // and optionally offers a read byte while SCL is high.
   task automatic scl_bit(input logic drv, input logic ld, input logic [7:0] ldata,
                          output logic pin, output logic oe);
      sda_m = drv; wait_q();
      scl_m = 1'b1; wait_q();
      pin = bus.sda_in;
      oe  = bus.sda_oe;
      if (ld) offer(ldata);
      wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic p, o;
      for (int i = 7; i >= 0; i--) scl_bit(b[i], 1'b0, 8'h00, p, o);
      scl_bit(1'b1, 1'b0, 8'h00, ack, o);
   endtask

   task automatic compare_state(input string tag);
      int n;
      wait_q();
      check({tag, "_n_start"}, n_start, exp_start);
      check({tag, "_n_stop"},  n_stop,  exp_stop);
      check({tag, "_n_under"}, n_under, exp_under);
      check({tag, "_evt_rw"},  bus.usr_evt_rw, exp_rw);
      check({tag, "_wready"},  bus.usr_wready, 1);
      check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_rx_byte"}, rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic xfer_write(input logic [6:0] a7, input int nbytes, input logic [7:0] v0);
      logic       ack, hit;
      logic [7:0] d;
      int         oe0;
      hit = (a7 == SLV);
      oe0 = n_oe;
      bus_start();
      send_byte({a7, 1'b0}, ack);
      check("wr_addr_ack", ack, hit ? 32'd0 : 32'd1);
      if (hit) begin
         exp_start++;
         exp_rw = 1'b0;
      end
      for (int k = 0; k < nbytes; k++) begin
         d = (k == 0) ? v0 : 8'($urandom);
         send_byte(d, ack);
         check("wr_data_ack", ack, hit ? 32'd0 : 32'd1);
         if (hit) exp_q.push_back(d);
      end
      bus_stop();
      if (hit) exp_stop++;
      else     check("nohit_wr_oe_cycles", n_oe - oe0, 0);
      compare_state("wr");
   endtask

   task automatic xfer_read(input logic [6:0] a7, input int nbytes, input logic [7:0] mask,
                            input logic [7:0] v0);
      logic       ack, hit, p, o, last;
      logic [7:0] got, exp_b;
      logic [7:0] val[8];
      int         oe0;
      hit = (a7 == SLV);
      for (int k = 0; k < 8; k++) val[k] = (k == 0) ? v0 : 8'($urandom);
      if (hit && mask[0]) offer(val[0]);
      oe0 = n_oe;
      bus_start();
      send_byte({a7, 1'b1}, ack);
      check("rd_addr_ack", ack, hit ? 32'd0 : 32'd1);
      if (!hit) begin
         bus_stop();
         check("nohit_rd_oe_cycles", n_oe - oe0, 0);
         compare_state("rd_nohit");
         return;
      end
      exp_start++;
      exp_rw = 1'b1;
      for (int k = 0; k < nbytes; k++) begin
         got = 8'h00;
         for (int i = 0; i < 8; i++) begin
            scl_bit(1'b1, 1'b0, 8'h00, p, o);
            got = {got[6:0], p};
         end
         exp_b = mask[k] ? val[k] : 8'hFF;
         if (!mask[k]) exp_under++;
         check("rd_byte", got, exp_b);
         last = (k == nbytes - 1);
         scl_bit(last, !last && mask[k+1], val[k+1], p, o);
         check("rd_ack_released", o, 0);
      end
      // After NACK the target must stay off the bus until STOP.
      oe0 = n_oe;
      for (int i = 0; i < 9; i++) scl_bit(1'b1, 1'b0, 8'h00, p, o);
      check("rd_wait_stop_quiet", n_oe - oe0, 0);
      bus_stop();
      exp_stop++;
      compare_state("rd");
   endtask

   initial begin
      logic       ack, p, o, hit, rw;
      logic [6:0] a7;
      logic [7:0] d;
      int         oe0;

      repeat (5) @(negedge clk_sys);
      rst = 1'b0;
      @(negedge clk_sys);
      check("rst_sda_oe",     bus.sda_oe, 0);
      check("rst_rvalid",     bus.usr_rvalid, 0);
      check("rst_rdata",      bus.usr_rdata, 8'h00);
      check("rst_wready",     bus.usr_wready, 1);
      check("rst_evt_start",  bus.usr_evt_start, 0);
      check("rst_evt_rw",     bus.usr_evt_rw, 0);
      check("rst_evt_stop",   bus.usr_evt_stop, 0);
      check("rst_underrun",   bus.dbg_err_underrun, 0);
      wait_q();

      // Matched write of 0x3C, unmatched address 0x51, preloaded read, underrun read.
      xfer_write(SLV, 1, 8'h3C);
      xfer_write(7'h51, 1, 8'h77);
      xfer_read(SLV, 1, 8'h01, 8'h96);
      xfer_read(SLV, 1, 8'h00, 8'h00);

      // Repeated START four bits into a write byte, then a read.
      bus_start();
      send_byte({SLV, 1'b0}, ack);
      check("rs_addr_ack", ack, 0);
      exp_start++;
      for (int i = 0; i < 4; i++) scl_bit(1'($urandom), 1'b0, 8'h00, p, o);
      xfer_read(SLV, 1, 8'h01, 8'h5A);

      // Reset while the target drives the write ACK.
      bus_start();
      send_byte({SLV, 1'b0}, ack);
      check("rst_mid_addr_ack", ack, 0);
      exp_start++;
      d = 8'($urandom);
      for (int i = 7; i >= 0; i--) scl_bit(d[i], 1'b0, 8'h00, p, o);
      exp_q.push_back(d);
      sda_m = 1'b1;
      wait_q();
      check("ack_before_rst", bus.sda_oe, 1);
      rst = 1'b1;
      @(negedge clk_sys);
      check("oe_after_rst", bus.sda_oe, 0);
      rst = 1'b0;
      exp_rw = 1'b0;
      oe0 = n_oe;
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
      for (int i = 0; i < 8; i++) scl_bit(1'($urandom), 1'b0, 8'h00, p, o);
      bus_stop();
      check("post_rst_oe_cycles", n_oe - oe0, 0);
      compare_state("post_rst");
      xfer_write(SLV, 2, 8'hC3);

      // Randomised mix of transactions.
      for (int t = 0; t < 12; t++) begin
         hit = ($urandom_range(0, 3) != 0);
         a7  = 7'($urandom);
         if (hit)             a7 = SLV;
         else if (a7 == SLV)  a7 = a7 ^ 7'h01;
         rw = 1'($urandom);
         if (rw) xfer_read(a7, $urandom_range(1, 3), 8'($urandom), 8'($urandom));
         else    xfer_write(a7, $urandom_range(1, 3), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/iic_s_phy_byterx.md
IIC_S_PHY_BYTERX -- requirements
Module: iic_s_phy_byterx

Interface
REQ-001 SHALL have parameter SLV_ADDR, default 7'h50, 7-bit target address matched against the address byte.
REQ-002 SHALL have parameter U_DLY, default 1, delay on register assignments (simulation only).
REQ-003 SHALL have ports:
- clk_sys  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 drives SDA low (open drain); 0 releases it.
- usr_rvalid  out  1  1-cycle pulse; usr_rdata holds a byte received from the master.
- usr_rdata  out  8  byte received from the master, MSB first.
- usr_wready  out  1  high while the read holding register is empty.
- usr_wvalid  in  1  byte offered for master reads; taken when usr_wvalid & usr_wready.
- usr_wdata  in  8  byte to be sent to the master.
- usr_evt_start  out  1  1-cycle pulse on an address match.
- usr_evt_rw  out  1  R/W bit of the matched address, held until the next match.
- usr_evt_stop  out  1  1-cycle pulse on STOP ending an addressed transaction.
- dbg_err_underrun  out  1  1-cycle pulse when a read byte was needed with the holding register empty.

Function
REQ-004 SHALL pass scl_in and sda_in through 2-flop synchronisers, then one compare register each; edge detects use the synchronised and compare values (3 clk_sys pin-to-event latency); clk_sys SHALL be at least 20x the SCL rate.
REQ-005 SHALL detect START as a synchronised SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-006 SHALL sample SDA on the synchronised SCL rising edge and change sda_oe only on the cycle after a synchronised SCL falling edge.
REQ-007 SHALL implement the FSM states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP, with a 3-bit bit counter.
REQ-008 SHALL go from any state to ADDR on START, clearing the bit counter and setting sda_oe=0; this covers repeated START, including mid-byte.
REQ-009 SHALL go from any state to IDLE on STOP with sda_oe=0, and pulse usr_evt_stop if the transaction was address-matched.
REQ-010 ADDR: after 8 sampled bits, if bits[7:1]==SLV_ADDR, pulse usr_evt_start, latch usr_evt_rw=bit0 and enter ADDR_ACK; otherwise enter WAIT_STOP with sda_oe held 0.
REQ-011 ADDR_ACK: on the next SCL fall drive sda_oe=1; on the following SCL fall go to WR_DATA if rw=0, or to RD_DATA if rw=1 and present the first read bit.
REQ-012 WR_DATA: shift in 8 bits; on the 8th SCL rise load usr_rdata and pulse usr_rvalid for one cycle; no backpressure; then go to WR_ACK.
REQ-013 WR_ACK: always ACK with sda_oe=1 from the next SCL fall to the one after it, then return to WR_DATA.
REQ-014 RD_DATA: at the SCL fall that starts a byte, move the holding register to the shift register and drive sda_oe=~bit, MSB first.
REQ-015 If the holding register is empty at the SCL fall that starts a byte, SHALL send 8'hFF and pulse dbg_err_underrun.
REQ-016 After 8 read bits, SHALL release SDA (sda_oe=0) for RD_ACK.
REQ-017 RD_ACK: sample SDA on SCL rise; 0 (ACK) returns to RD_DATA for the next byte; 1 (NACK) goes to WAIT_STOP with SDA released.
REQ-018 The holding register SHALL be one entry with a valid flag.
- usr_wready = ~valid.
- Load on handshake; clear on transfer to the shift register.
- A load and a clear in the same cycle SHALL leave valid set with the new byte.
REQ-019 START and STOP detection SHALL take priority over any concurrent SCL-edge action in the same cycle.
REQ-020 SHALL not stretch SCL; no general-call or 10-bit address support.

Reset
REQ-021 On rst, SHALL force state IDLE and bit counter 0, and set the sync flops to 1.
REQ-022 On rst, SHALL clear sda_oe, all pulse outputs, usr_rdata=8'h00, usr_evt_rw=0 and holding valid=0; usr_wready=1 from the first cycle after rst falls.
REQ-023 Reset asserted mid-transfer SHALL release SDA on the next clk_sys edge; after reset the block SHALL ignore bus activity until the next START.

Verification
REQ-024 START, address 0xA0, data 0x3C, STOP -> sda_oe ACK on both 9th clocks; usr_evt_start with usr_evt_rw=0; usr_rvalid with usr_rdata=0x3C; usr_evt_stop.
REQ-025 START, address 0xA2 (0x51) -> sda_oe stays 0 through the byte and the 9th clock; no events and no usr_rvalid until STOP.
REQ-026 0x96 preloaded, START, address 0xA1, master NACK -> SDA bits 1,0,0,1,0,1,1,0; SDA released on the 9th clock; WAIT_STOP; usr_evt_stop at STOP.
REQ-027 Read with no preload -> 0xFF sent, dbg_err_underrun pulsed once, usr_wready stays 1.
REQ-028 Repeated START after 4 data bits of a write -> no usr_rvalid; new address decoded; 0xA1 enters the read path.
REQ-029 rst pulsed while sda_oe=1 during ACK -> sda_oe=0 the next cycle; no events until a new START.
